ring_phase_mon: RTL and testbench
=================================

// Module: ring_phase_mon
// PURPOSE
//  Downstream consumer of the N-bit one-hot ring counter. It samples the ring state every clk
//  and encodes it to a binary phase index. It checks that the ring is one-hot and that it
//  advances exactly one position per clock. It also counts completed revolutions for the
//  sequencing logic. Errors are sticky and flag ring corruption, e.g. SEU or a bad preset.
// PARAMETERS
//  reg_size  4  ring width N; must match the ring counter; N>=2
//  rev_w     8  width of revolution counter (wraps modulo 2^rev_w)
//  ecnt_w    4  width of saturating error counter
// PORTS
//  clk       in   1               rising-edge clock, same clock as the ring counter
//  clr       in   1               async active-low reset; asserted 0 clears all state immediately
//  ring_q    in   reg_size        one-hot ring state from the ring counter
//  err_clr   in   1               sync pulse: clears sticky errors, returns FSM to S_INIT
//  phase     out  clog2(reg_size) binary index of the active bit (registered)
//  phase_vld out  1               phase is valid: sample was one-hot and FSM is in S_TRACK
//  rev_tick  out  1               1-cycle pulse when the ring wraps from bit N-1 to bit 0
//  rev_cnt   out  rev_w           revolutions since reset or err_clr
//  oh_err    out  1               sticky: a non-one-hot sample was seen (zero or >1 bits set)
//  seq_err   out  1               sticky: a one-hot sample was not rotate-left-by-1 of the previous one
//  err_cnt   out  ecnt_w          saturating count of error events (oh or seq) since reset/err_clr
// BEHAVIOUR
//  - Reset (clr=0, async): phase=0, phase_vld=0, rev_tick=0, rev_cnt=0, oh_err=0, seq_err=0,
//    err_cnt=0, prev_q=0, FSM=S_INIT. All outputs are registered; latency is 1 clk from ring_q.
//  - Encoding: phase = index of the single set bit of ring_q. Illegal samples leave phase
//    holding its last value and force phase_vld=0.
//  - FSM states: S_INIT, S_TRACK, S_FAULT.
//  - S_INIT: if the sample is one-hot, capture prev_q, then S_TRACK, phase_vld=1 next cycle.
//    Otherwise stay in S_INIT, set oh_err, err_cnt++.
//  - S_TRACK, sample not one-hot: oh_err=1, err_cnt++, go to S_FAULT.
//  - S_TRACK, sample one-hot but != {prev_q[N-2:0],prev_q[N-1]}: seq_err=1, err_cnt++,
//    go to S_FAULT.
//  - S_TRACK, sample correct: update prev_q. If prev_q[N-1]=1 and ring_q[0]=1, pulse rev_tick,
//    rev_cnt++ (wraps 2^rev_w-1 -> 0).
//  - S_FAULT: phase_vld=0, no rev counting, no further err_cnt increments. Exit only via
//    err_clr or reset.
//  - err_clr (sync, any state): clears oh_err, seq_err, err_cnt, rev_cnt and prev_q; next
//    state S_INIT. err_clr wins over a same-cycle error or rev_tick; that cycle's event is
//    dropped.
//  - err_cnt saturates at 2^ecnt_w-1. Multiple simultaneous errors count as one event.
//  - Ring reset pattern is q=0..01 (bit 0 preset). After both blocks leave reset, the first
//    edge captures phase=0 and the FSM enters S_TRACK.
//  - clr asserted mid-revolution: everything returns to reset values immediately, no pulse
//    is emitted.
// STRUCTURE
//  - Shared header ring_defs.vh: FSM state encodings (S_INIT=2'd0, S_TRACK=2'd1,
//    S_FAULT=2'd2), clog2 constant function, default reg_size.
//  - One sub-module, onehot_enc #(reg_size): combinational; outputs idx and is_onehot.
//  - Top level holds prev_q, the FSM, the counters and the sticky flags.
// TESTING (reg_size=4, rev_w=8, ecnt_w=4)
//  - Reset release, ring_q 0001,0010,0100,1000,0001 -> phase 0,1,2,3,0 one clk late;
//    phase_vld=1 from 2nd clk; rev_tick on 0001 after 1000; rev_cnt=1.
//  - 256 clean revolutions -> rev_cnt wraps to 0 on the 256th rev_tick; no errors.
//  - In S_TRACK inject 0110 -> oh_err=1, err_cnt=1, phase_vld=0, phase holds last value;
//    later legal samples are ignored (err_cnt stays 1, rev_cnt frozen).
//  - In S_TRACK skip a step (0010 then 1000) -> seq_err=1, oh_err=0, FSM=S_FAULT.
//  - err_clr pulse in S_FAULT, same cycle as an illegal 0000 -> all errors 0, rev_cnt=0,
//    S_INIT next; then 0100 locks with phase=2.
//  - Hold ring_q=0000 in S_INIT for 20 clks -> err_cnt saturates at 15. Also assert clr
//    mid-run between clk edges -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/ring_phase_mon_pkg.sv
// Shared types and helpers for the ring counter phase monitor.
// FSM state encoding, default ring width and a width helper.
package ring_phase_mon_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam int unsigned REG_SIZE_DEF = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ring_phase_mon_enc.sv
// One-hot to binary encoder for the ring phase monitor.
// Purely combinational; idx is only meaningful when is_onehot is set.
module onehot_enc
  import ring_phase_mon_pkg::*;
#(
  parameter int unsigned reg_size = REG_SIZE_DEF,
  localparam int unsigned PW = clog2(reg_size)
) (
  input  logic [reg_size-1:0] vec,
  output logic [PW-1:0]       idx,
  output logic                is_onehot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(reg_size); i++) begin
      if (vec[i]) idx = idx | PW'(i);
    end
    is_onehot = (vec != '0) &&
                ((vec & (vec - reg_size'(1))) == '0);
  end

endmodule

// File: rtl/ring_phase_mon.sv
// Ring counter phase monitor: encodes the one-hot ring to a phase,
// checks rotation order, counts revolutions and sticky error events.
module ring_phase_mon
  import ring_phase_mon_pkg::*;
#(
  parameter int unsigned reg_size = REG_SIZE_DEF,
  parameter int unsigned rev_w    = 8,
  parameter int unsigned ecnt_w   = 4,
  localparam int unsigned PW = clog2(reg_size)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [reg_size-1:0] ring_q,
  input  logic                err_clr,
  output logic [PW-1:0]       phase,
  output logic                phase_vld,
  output logic                rev_tick,
  output logic [rev_w-1:0]    rev_cnt,
  output logic                oh_err,
  output logic                seq_err,
  output logic [ecnt_w-1:0]   err_cnt
);

  state_e              state_q, state_d;
  logic [reg_size-1:0] prev_q, prev_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic                vld_q, vld_d;
  logic                tick_q, tick_d;
  logic [rev_w-1:0]    rev_q, rev_d;
  logic                oh_q, oh_d;
  logic                seq_q, seq_d;
  logic [ecnt_w-1:0]   ecnt_q, ecnt_d;

  logic [PW-1:0]       enc_idx;
  logic                enc_oh;
  logic [reg_size-1:0] rot;
  logic                oh_ev, seq_ev;

  onehot_enc #(.reg_size(reg_size)) u_enc (
    .vec       (ring_q),
    .idx       (enc_idx),
    .is_onehot (enc_oh)
  );

  assign rot = {prev_q[reg_size-2:0], prev_q[reg_size-1]};

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    phase_d = phase_q;
    vld_d   = 1'b0;
    tick_d  = 1'b0;
    rev_d   = rev_q;
    oh_d    = oh_q;
    seq_d   = seq_q;
    ecnt_d  = ecnt_q;
    oh_ev   = 1'b0;
    seq_ev  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (enc_oh) begin
          prev_d  = ring_q;
          phase_d = enc_idx;
          vld_d   = 1'b1;
          state_d = S_TRACK;
        end else begin
          oh_ev = 1'b1;
        end
      end
      S_TRACK: begin
        if (!enc_oh) begin
          oh_ev   = 1'b1;
          state_d = S_FAULT;
        end else if (ring_q != rot) begin
          seq_ev  = 1'b1;
          state_d = S_FAULT;
        end else begin
          prev_d  = ring_q;
          phase_d = enc_idx;
          vld_d   = 1'b1;
          if (prev_q[reg_size-1] && ring_q[0]) begin
            tick_d = 1'b1;
            rev_d  = rev_q + rev_w'(1);
          end
        end
      end
      S_FAULT: ;
      default: state_d = S_INIT;
    endcase
    if (oh_ev) oh_d = 1'b1;
    if (seq_ev) seq_d = 1'b1;
    // one event per cycle, even if both flags could apply
    if ((oh_ev || seq_ev) && ecnt_q != '1)
      ecnt_d = ecnt_q + ecnt_w'(1);
    if (err_clr) begin
      state_d = S_INIT;
      prev_d  = '0;
      vld_d   = 1'b0;
      tick_d  = 1'b0;
      rev_d   = '0;
      oh_d    = 1'b0;
      seq_d   = 1'b0;
      ecnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_INIT;
      prev_q  <= '0;
      phase_q <= '0;
      vld_q   <= 1'b0;
      tick_q  <= 1'b0;
      rev_q   <= '0;
      oh_q    <= 1'b0;
      seq_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      phase_q <= phase_d;
      vld_q   <= vld_d;
      tick_q  <= tick_d;
      rev_q   <= rev_d;
      oh_q    <= oh_d;
      seq_q   <= seq_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = vld_q;
  assign rev_tick  = tick_q;
  assign rev_cnt   = rev_q;
  assign oh_err    = oh_q;
  assign seq_err   = seq_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_ring_phase_mon.sv
// Directed bench for ring_phase_mon with reg_size=4.
// Expected values are hand-derived from the ring sequence.
module tb_ring_phase_mon;
  import ring_phase_mon_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] ring_q;
  logic       err_clr;
  logic [1:0] phase;
  logic       phase_vld;
  logic       rev_tick;
  logic [7:0] rev_cnt;
  logic       oh_err;
  logic       seq_err;
  logic [3:0] err_cnt;

  int tests = 0;
  int fails = 0;

  ring_phase_mon #(.reg_size(4), .rev_w(8), .ecnt_w(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .ring_q    (ring_q),
    .err_clr   (err_clr),
    .phase     (phase),
    .phase_vld (phase_vld),
    .rev_tick  (rev_tick),
    .rev_cnt   (rev_cnt),
    .oh_err    (oh_err),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v);
    ring_q = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr     = 1'b0;
    err_clr = 1'b0;
    ring_q  = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_vld", 32'(phase_vld), 0);
    chk("rst_tick", 32'(rev_tick), 0);
    chk("rst_rev", 32'(rev_cnt), 0);
    chk("rst_oh", 32'(oh_err), 0);
    chk("rst_seq", 32'(seq_err), 0);
    chk("rst_ecnt", 32'(err_cnt), 0);
    chk("rst_state", 32'(dut.state_q), 32'(S_INIT));
    clr = 1'b1;

    step(4'b0001);
    chk("lock_phase", 32'(phase), 0);
    chk("lock_vld", 32'(phase_vld), 1);
    chk("lock_tick", 32'(rev_tick), 0);
    step(4'b0010);
    chk("ph1", 32'(phase), 1);
    step(4'b0100);
    chk("ph2", 32'(phase), 2);
    step(4'b1000);
    chk("ph3", 32'(phase), 3);
    chk("ph3_tick", 32'(rev_tick), 0);
    step(4'b0001);
    chk("wrap_phase", 32'(phase), 0);
    chk("wrap_tick", 32'(rev_tick), 1);
    chk("wrap_rev", 32'(rev_cnt), 1);
    step(4'b0010);
    chk("tick_pulse", 32'(rev_tick), 0);

    for (int r = 0; r < 254; r++) begin
      step(4'b0100);
      step(4'b1000);
      step(4'b0001);
      step(4'b0010);
    end
    chk("rev_255", 32'(rev_cnt), 255);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    chk("rev_wrap_tick", 32'(rev_tick), 1);
    chk("rev_wrap_cnt", 32'(rev_cnt), 0);
    chk("clean_oh", 32'(oh_err), 0);
    chk("clean_seq", 32'(seq_err), 0);
    chk("clean_ecnt", 32'(err_cnt), 0);

    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    chk("rev_one", 32'(rev_cnt), 1);
    step(4'b0110);
    chk("oh_err", 32'(oh_err), 1);
    chk("oh_ecnt", 32'(err_cnt), 1);
    chk("oh_vld", 32'(phase_vld), 0);
    chk("oh_phase_hold", 32'(phase), 0);
    chk("oh_state", 32'(dut.state_q), 32'(S_FAULT));
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    chk("fault_ecnt", 32'(err_cnt), 1);
    chk("fault_rev", 32'(rev_cnt), 1);
    chk("fault_vld", 32'(phase_vld), 0);
    chk("fault_tick", 32'(rev_tick), 0);

    err_clr = 1'b1;
    step(4'b0000);
    err_clr = 1'b0;
    chk("clr_oh", 32'(oh_err), 0);
    chk("clr_seq", 32'(seq_err), 0);
    chk("clr_ecnt", 32'(err_cnt), 0);
    chk("clr_rev", 32'(rev_cnt), 0);
    chk("clr_state", 32'(dut.state_q), 32'(S_INIT));
    step(4'b0100);
    chk("relock_phase", 32'(phase), 2);
    chk("relock_vld", 32'(phase_vld), 1);

    step(4'b1000);
    step(4'b0001);
    chk("relock_rev", 32'(rev_cnt), 1);
    step(4'b0010);
    chk("pre_skip_phase", 32'(phase), 1);
    step(4'b1000);
    chk("skip_seq", 32'(seq_err), 1);
    chk("skip_oh", 32'(oh_err), 0);
    chk("skip_ecnt", 32'(err_cnt), 1);
    chk("skip_phase", 32'(phase), 1);
    chk("skip_vld", 32'(phase_vld), 0);
    chk("skip_state", 32'(dut.state_q), 32'(S_FAULT));

    err_clr = 1'b1;
    step(4'b0000);
    err_clr = 1'b0;
    chk("clr2_ecnt", 32'(err_cnt), 0);
    chk("clr2_seq", 32'(seq_err), 0);
    for (int i = 0; i < 14; i++) step(4'b0000);
    chk("sat_14", 32'(err_cnt), 14);
    step(4'b0000);
    chk("sat_15", 32'(err_cnt), 15);
    for (int i = 0; i < 5; i++) step(4'b0000);
    chk("sat_hold", 32'(err_cnt), 15);
    chk("sat_oh", 32'(oh_err), 1);
    chk("sat_state", 32'(dut.state_q), 32'(S_INIT));

    step(4'b0001);
    step(4'b0010);
    chk("pre_clr_phase", 32'(phase), 1);
    chk("pre_clr_vld", 32'(phase_vld), 1);
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    chk("aclr_phase", 32'(phase), 0);
    chk("aclr_vld", 32'(phase_vld), 0);
    chk("aclr_tick", 32'(rev_tick), 0);
    chk("aclr_oh", 32'(oh_err), 0);
    chk("aclr_ecnt", 32'(err_cnt), 0);
    chk("aclr_state", 32'(dut.state_q), 32'(S_INIT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
